// File: rtl/eth_types_pkg.sv
// Shared Ethernet TX types: arbiter state encoding and frame timing constants.
// Combinational helpers only; no storage and no flow control.
package eth_types_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      GAP    = 2'd3
   } tx_arb_states;

   localparam int ETH_IFG_BYTES    = 12;
   localparam int ETH_MAX_FRAME    = 1514;
   localparam int ETH_CLK_PER_BYTE = 4;

   // RMII moves two bits per 50 MHz clock, so one byte spans four clocks.
   function automatic int byte_times_to_clks(input int nbytes);
      return nbytes * ETH_CLK_PER_BYTE;
   endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_picker.sv
// rr_picker: one-hot round-robin winner, search begins one past rr_ptr.
// Latency: purely combinational. Backpressure: none, pure function of req/rr_ptr.
// ETH_TX_ARB_PRIORITY_EN: requester 0 overrides; the others rotate among themselves.
module rr_picker #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]         winner
);
   localparam int PW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   cand;
   logic [NUM_REQ-1:0]   rot_lo;
   logic [NUM_REQ-1:0]   first;
   logic [2*NUM_REQ-1:0] win_dbl;
   logic [PW:0]          start;

   // Rotate so the search start sits at bit 0, take the lowest set bit, rotate back.
   // A shift of NUM_REQ is equivalent to zero, so no modulo is needed.
   always_comb begin
`ifdef ETH_TX_ARB_PRIORITY_EN
      cand = req & ~NUM_REQ'(1);
`else
      cand = req;
`endif
      start   = {1'b0, rr_ptr} + (PW+1)'(1);
      rot_lo  = NUM_REQ'({cand, cand} >> start);
      first   = rot_lo & (~rot_lo + NUM_REQ'(1));
      win_dbl = {{NUM_REQ{1'b0}}, first} << start;
      winner  = win_dbl[NUM_REQ-1:0] | win_dbl[2*NUM_REQ-1:NUM_REQ];
`ifdef ETH_TX_ARB_PRIORITY_EN
      if (req[0]) begin
         winner = NUM_REQ'(1);
      end
`endif
   end

endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: grants one byte-stream requester the TX path, enforces IFG and max length.
// Latency: 1 clk req->grant, 0 clk data pass-through while streaming.
// Backpressure: tx_ready routed to the owner's src_ready; excess bytes sunk after truncation.
// ETH_TX_ARB_PRIORITY_EN (in rr_picker) gives requester 0 fixed priority.
module eth_tx_arbiter
   import eth_types_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int IFG_CYCLES      = byte_times_to_clks(ETH_IFG_BYTES),
   parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*8-1:0] src_byte,
   input  logic [NUM_REQ-1:0]   src_valid,
   input  logic [NUM_REQ-1:0]   src_last,
   output logic [NUM_REQ-1:0]   src_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic [7:0]           tx_byte,
   output logic                 tx_valid,
   output logic                 tx_last,
   input  logic                 tx_ready,
   output logic                 busy,
   output logic                 frame_trunc
);
   localparam int          PW        = $clog2(NUM_REQ);
   localparam logic [15:0] TRUNC_CNT = 16'(MAX_FRAME_BYTES - 1);
   localparam logic [15:0] GAP_LOAD  = 16'(IFG_CYCLES - 1);

   tx_arb_states       state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [PW-1:0]      gidx_q, gidx_d;
   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [15:0]        byte_cnt_q, byte_cnt_d;
   logic [15:0]        gap_cnt_q, gap_cnt_d;

   logic [NUM_REQ-1:0] winner;
   logic [PW-1:0]      win_idx;
   logic [7:0]         g_byte;
   logic               g_valid;
   logic               g_last;
   logic               hs;
   logic               trunc_hit;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_rr_picker (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .winner (winner)
   );

   always_comb begin
      win_idx = '0;
      g_byte  = '0;
      g_valid = 1'b0;
      g_last  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner[i]) begin
            win_idx = PW'(i);
         end
         if (gidx_q == PW'(i)) begin
            g_byte  = src_byte[i*8 +: 8];
            g_valid = src_valid[i];
            g_last  = src_last[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      gidx_d      = gidx_q;
      rr_ptr_d    = rr_ptr_q;
      byte_cnt_d  = byte_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      src_ready   = '0;
      tx_byte     = '0;
      tx_valid    = 1'b0;
      tx_last     = 1'b0;
      frame_trunc = 1'b0;
      trunc_hit   = (byte_cnt_q == TRUNC_CNT);
      hs          = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d    = winner;
               gidx_d     = win_idx;
               byte_cnt_d = '0;
               state_d    = STREAM;
            end
         end

         STREAM: begin
            tx_byte   = g_byte;
            tx_valid  = g_valid;
            tx_last   = g_valid & (g_last | trunc_hit);
            src_ready = grant_q & {NUM_REQ{tx_ready}};
            hs        = g_valid & tx_ready;
            if (hs) begin
               if (byte_cnt_q != 16'hFFFF) begin
                  byte_cnt_d = byte_cnt_q + 16'd1;
               end
               // A genuine last on the limit byte ends normally, without a trunc pulse.
               if (g_last) begin
                  state_d   = GAP;
                  rr_ptr_d  = gidx_q;
                  grant_d   = '0;
                  gap_cnt_d = GAP_LOAD;
               end else if (trunc_hit) begin
                  frame_trunc = 1'b1;
                  state_d     = DRAIN;
               end
            end
         end

         DRAIN: begin
            src_ready = grant_q;
            if (g_valid & g_last) begin
               state_d   = GAP;
               rr_ptr_d  = gidx_q;
               grant_d   = '0;
               gap_cnt_d = GAP_LOAD;
            end
         end

         GAP: begin
            if (gap_cnt_q == 16'd0) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 16'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         rr_ptr_q   <= PW'(NUM_REQ - 1);
         byte_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         rr_ptr_q   <= rr_ptr_d;
         byte_cnt_q <= byte_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   assign grant = grant_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: default-length instance (a) and a 16-byte-limit instance (b).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_eth_tx_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  req;
   logic [15:0] src_byte;
   logic [1:0]  src_valid;
   logic [1:0]  src_last;
   logic        tx_ready;

   logic [1:0]  src_ready_a, grant_a, src_ready_b, grant_b;
   logic [7:0]  tx_byte_a, tx_byte_b;
   logic        tx_valid_a, tx_last_a, busy_a, frame_trunc_a;
   logic        tx_valid_b, tx_last_b, busy_b, frame_trunc_b;

   logic        sel_b;
   logic [1:0]  o_src_ready, o_grant;
   logic [7:0]  o_tx_byte;
   logic        o_tx_valid, o_tx_last, o_busy, o_frame_trunc;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   eth_tx_arbiter #(.NUM_REQ(2)) dut_a (
      .clk(clk), .resetn(resetn), .req(req), .src_byte(src_byte),
      .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready_a),
      .grant(grant_a), .tx_byte(tx_byte_a), .tx_valid(tx_valid_a),
      .tx_last(tx_last_a), .tx_ready(tx_ready), .busy(busy_a),
      .frame_trunc(frame_trunc_a)
   );

   eth_tx_arbiter #(.NUM_REQ(2), .MAX_FRAME_BYTES(16)) dut_b (
      .clk(clk), .resetn(resetn), .req(req), .src_byte(src_byte),
      .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready_b),
      .grant(grant_b), .tx_byte(tx_byte_b), .tx_valid(tx_valid_b),
      .tx_last(tx_last_b), .tx_ready(tx_ready), .busy(busy_b),
      .frame_trunc(frame_trunc_b)
   );

   assign o_src_ready   = sel_b ? src_ready_b   : src_ready_a;
   assign o_grant       = sel_b ? grant_b       : grant_a;
   assign o_tx_byte     = sel_b ? tx_byte_b     : tx_byte_a;
   assign o_tx_valid    = sel_b ? tx_valid_b    : tx_valid_a;
   assign o_tx_last     = sel_b ? tx_last_b     : tx_last_a;
   assign o_busy        = sel_b ? busy_b        : busy_a;
   assign o_frame_trunc = sel_b ? frame_trunc_b : frame_trunc_a;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] bval(input int s, input int k);
      return 8'(s * 64 + k + 1);
   endfunction

   task automatic reset_all();
      resetn    = 1'b0;
      req       = '0;
      src_byte  = '0;
      src_valid = '0;
      src_last  = '0;
      tx_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   // Source model: presents byte k until accepted; tallies what the TX side saw.
   task automatic run_frame(input int src, input int n, input bit toggle, input int rst_at,
                            output int hs, output int last_at, output int trunc_at,
                            output int drain_acc, output int errs, output bit to);
      int k;
      k = 0; hs = 0; last_at = 0; trunc_at = 0; drain_acc = 0; errs = 0; to = 1'b1;
      for (int cyc = 0; cyc < 500; cyc++) begin
         tx_ready  = toggle ? ((cyc % 2) == 0) : 1'b1;
         src_valid = '0;
         src_last  = '0;
         src_valid[src] = 1'b1;
         src_byte[src*8 +: 8] = bval(src, k);
         src_last[src] = (k == n - 1);
         if (rst_at > 0 && k == rst_at - 1) begin
            resetn = 1'b0;
            @(posedge clk);
            #1;
            to = 1'b0;
            break;
         end
         @(negedge clk);
         if (o_tx_last && !o_tx_valid) errs++;
         if ((o_src_ready & ~(2'b01 << src)) != 2'b00) errs++;
         if (o_tx_valid && (o_src_ready[src] !== tx_ready)) errs++;
         if (o_tx_valid && (o_tx_byte !== bval(src, k))) errs++;
         if (o_src_ready[src]) begin
            if (o_tx_valid) begin
               hs++;
               if (o_tx_last) last_at = hs;
               if (o_frame_trunc) trunc_at = hs;
            end else begin
               drain_acc++;
            end
            k++;
         end
         @(posedge clk);
         #1;
         if (k == n) begin
            to = 1'b0;
            break;
         end
      end
      src_valid = '0;
      src_last  = '0;
      tx_ready  = 1'b1;
   endtask

   // Called one unit after the edge that closed the final handshake; counts edges to idle.
   task automatic busy_span(output int n);
      n = 1;
      while (o_busy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic wait_grant(output bit to);
      to = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (o_grant != 2'b00) begin
            to = 1'b0;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   int         hs, last_at, trunc_at, drain_acc, errs, span;
   bit         to;
   logic [1:0] seen_g [3];
   logic [1:0] exp_g  [3];

   initial begin
      sel_b = 1'b0;

      // Reset state
      reset_all();
      @(negedge clk);
      chk("rst_grant", grant_a, 2'b00);
      chk("rst_src_ready", src_ready_a, 2'b00);
      chk("rst_tx_valid", tx_valid_a, 1'b0);
      chk("rst_tx_last", tx_last_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_trunc", frame_trunc_a, 1'b0);
      chk("rst_tx_byte", tx_byte_a, 8'h00);
      @(posedge clk);
      #1;

      // 60-byte frame from requester 0
      req = 2'b01;
      #1;
      chk("t1_grant_before", grant_a, 2'b00);
      @(posedge clk);
      #1;
      chk("t1_grant_after_1clk", grant_a, 2'b01);
      run_frame(0, 60, 1'b0, 0, hs, last_at, trunc_at, drain_acc, errs, to);
      req = 2'b00;
      chk("t1_timeout", to, 1'b0);
      chk("t1_handshakes", hs, 60);
      chk("t1_last_pos", last_at, 60);
      chk("t1_no_trunc", trunc_at, 0);
      chk("t1_errs", errs, 0);
      chk("t1_grant_cleared", grant_a, 2'b00);
      busy_span(span);
      chk("t1_busy_span", span, 49);

      // Three frames with both requesters held
      reset_all();
      req = 2'b11;
`ifdef ETH_TX_ARB_PRIORITY_EN
      exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01;
`else
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
`endif
      for (int f = 0; f < 3; f++) begin
         wait_grant(to);
         chk("t2_grant_timeout", to, 1'b0);
         seen_g[f] = o_grant;
         run_frame((o_grant == 2'b10) ? 1 : 0, 4, 1'b0, 0,
                   hs, last_at, trunc_at, drain_acc, errs, to);
         chk("t2_frame_hs", hs, 4);
      end
      req = 2'b00;
      chk("t2_grant0", seen_g[0], exp_g[0]);
      chk("t2_grant1", seen_g[1], exp_g[1]);
      chk("t2_grant2", seen_g[2], exp_g[2]);

      // 20-byte frame with tx_ready toggling
      reset_all();
      req = 2'b01;
      run_frame(0, 20, 1'b1, 0, hs, last_at, trunc_at, drain_acc, errs, to);
      req = 2'b00;
      chk("t3_timeout", to, 1'b0);
      chk("t3_handshakes", hs, 20);
      chk("t3_last_pos", last_at, 20);
      chk("t3_stall_mirror_errs", errs, 0);

      // Truncation at 16 bytes on a 20-byte source frame
      reset_all();
      sel_b = 1'b1;
      req   = 2'b01;
      run_frame(0, 20, 1'b0, 0, hs, last_at, trunc_at, drain_acc, errs, to);
      req = 2'b00;
      chk("t4_timeout", to, 1'b0);
      chk("t4_handshakes", hs, 16);
      chk("t4_last_pos", last_at, 16);
      chk("t4_trunc_pos", trunc_at, 16);
      chk("t4_drained", drain_acc, 4);
      chk("t4_errs", errs, 0);
      chk("t4_busy_gap", busy_b, 1'b1);
      chk("t4_grant_cleared", grant_b, 2'b00);

      // Last coincides with the limit byte: normal end, no truncation
      reset_all();
      req = 2'b01;
      run_frame(0, 16, 1'b0, 0, hs, last_at, trunc_at, drain_acc, errs, to);
      req = 2'b00;
      chk("t6_timeout", to, 1'b0);
      chk("t6_handshakes", hs, 16);
      chk("t6_last_pos", last_at, 16);
      chk("t6_no_trunc", trunc_at, 0);
      chk("t6_no_drain", drain_acc, 0);
      busy_span(span);
      chk("t6_busy_span", span, 49);
      sel_b = 1'b0;

      // Reset on byte 5 of a frame
      reset_all();
      req = 2'b01;
      run_frame(0, 20, 1'b0, 5, hs, last_at, trunc_at, drain_acc, errs, to);
      chk("t5_hs_before_rst", hs, 4);
      chk("t5_no_last", last_at, 0);
      @(negedge clk);
      chk("t5_grant", grant_a, 2'b00);
      chk("t5_src_ready", src_ready_a, 2'b00);
      chk("t5_tx_valid", tx_valid_a, 1'b0);
      chk("t5_tx_last", tx_last_a, 1'b0);
      chk("t5_busy", busy_a, 1'b0);
      chk("t5_tx_byte", tx_byte_a, 8'h00);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      req    = 2'b10;
      @(posedge clk);
      #1;
      chk("t5_regrant", grant_a, 2'b10);
      req = 2'b00;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Shares the single Ethernet transmit path (frame builder → LAN8720 RMII TX) between several byte-stream requesters, such as the UDP reply generator and an ARP responder. Grants one requester at a time and passes its bytes through with zero added latency. Enforces the inter-frame gap and a maximum frame length. Sits between the protocol-level packet generators and the TX MAC/frame builder, mirroring the RX-side parser.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- IFG_CYCLES, 48, idle clocks after each frame (12 byte-times at 4 clk/byte on RMII)
- MAX_FRAME_BYTES, 1514, byte limit per grant before forced truncation

Ports:
- clk  in  1  50MHz LAN8720 reference clock; single clock domain
- resetn  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester frame request; held until its last byte is accepted
- src_byte  in  NUM_REQ*8  requester data; requester i on bits [8i+7:8i]
- src_valid  in  NUM_REQ  per-requester byte valid
- src_last  in  NUM_REQ  marks the requester's final byte
- src_ready  out  NUM_REQ  per-requester accept
- grant  out  NUM_REQ  one-hot, registered current owner
- tx_byte  out  8  byte to frame builder
- tx_valid  out  1  byte valid to frame builder
- tx_last  out  1  final byte of frame
- tx_ready  in  1  frame builder accept
- busy  out  1  high in any state other than IDLE
- frame_trunc  out  1  one-cycle pulse when a frame is cut at MAX_FRAME_BYTES

## Operation
- States: IDLE, STREAM, DRAIN, GAP. The state type belongs in the shared package.
- IDLE:
  - If any req bit is set, select a winner, register its one-hot grant, clear byte_cnt, and go to STREAM.
  - Round-robin search starts at rr_ptr+1 (mod NUM_REQ).
- STREAM: combinational pass-through from the granted index g.
  - tx_byte = src_byte[g]; tx_valid = src_valid[g]; tx_last = src_last[g] | trunc_hit.
  - src_ready[g] = tx_ready. All other src_ready bits are 0.
  - A handshake is tx_valid & tx_ready. Each handshake increments byte_cnt (16-bit, saturating).
  - Handshake with src_last[g]: go to GAP, set rr_ptr ← g, clear grant.
  - trunc_hit = (byte_cnt == MAX_FRAME_BYTES-1). A handshake with trunc_hit and no src_last: assert tx_last, pulse frame_trunc, go to DRAIN.
- DRAIN:
  - src_ready[g] = 1 and tx_valid = 0, so remaining source bytes are discarded.
  - On src_valid[g] & src_last[g]: go to GAP, set rr_ptr ← g, clear grant.
- GAP:
  - Load gap_cnt = IFG_CYCLES-1 on entry and decrement every clock.
  - At 0, go to IDLE. req is ignored throughout.
- req dropped by the owner mid-frame is ignored. The grant is held until last or truncation.
- Simultaneous last and trunc_hit on the same handshake: a normal end. No frame_trunc, go to GAP.

## Timing
- Reset (resetn=0 at a clk edge):
  - State → IDLE; grant, src_ready, tx_valid, tx_last, busy, frame_trunc → 0; tx_byte → 0.
  - rr_ptr → NUM_REQ-1, so requester 0 is searched first. byte_cnt and gap_cnt → 0.
- Reset mid-frame abandons the frame with no tx_last. The downstream block is reset in the same cycle.
- Request to first possible handshake latency: 1 clk (req sampled in IDLE → grant valid next cycle).
- Data path latency: 0 clk in STREAM.
- Last handshake to next grant: IFG_CYCLES+1 clk minimum (GAP plus one IDLE arbitration cycle).
- tx_last is only asserted while tx_valid is asserted.

## Configuration
- ETH_TX_ARB_PRIORITY_EN defined:
  - Requester 0 has fixed priority. It wins in IDLE whenever req[0]=1.
  - The remaining requesters are served round-robin among themselves.
- Undefined: pure round-robin over all requesters.

## Structure
- eth_types_pkg additions:
  - tx_arb_states enum (IDLE, STREAM, DRAIN, GAP).
  - Constants ETH_IFG_BYTES = 12 and ETH_MAX_FRAME = 1514.
- Sub-module rr_picker:
  - Combinational one-hot round-robin selector.
  - Inputs: req and rr_ptr. Output: one-hot winner.
  - Instantiated once. The priority macro wraps its req[0] override.

## Test plan
- Single request, frame of 60 bytes from req[0] with tx_ready=1:
  - grant=2'b01 one clk after req.
  - 60 handshakes; tx_last on byte 60.
  - busy low exactly 49 clks after the last handshake (48 GAP + exit).
- req=2'b11 held for three frames:
  - Grants alternate 01, 10, 01.
  - With ETH_TX_ARB_PRIORITY_EN, all three grants are 01.
- tx_ready toggled 1/0 each cycle during a 20-byte frame:
  - Exactly 20 handshakes, tx_byte stable while stalled, src_ready[g] mirrors tx_ready.
- MAX_FRAME_BYTES=16, source sends 20 bytes:
  - tx_last and frame_trunc on byte 16.
  - Bytes 17–20 are accepted in DRAIN with tx_valid=0, then GAP.
- resetn=0 asserted on byte 5 of a frame:
  - All outputs 0 the next clk.
  - A fresh req[1] is granted one clk after resetn returns high.
- src_last on handshake 16 with MAX_FRAME_BYTES=16:
  - No frame_trunc pulse; direct transition to GAP.
